uop_group_queue: RTL and testbench
==================================

# uop_group_queue

Multi-entry, parametrised reservation queue between instruction decode and the execute scheduler. It buffers up to DEPTH decoded micro-op groups, each carrying up to SLOTS micro-ops and one K_W-bit operand/temp word, and issues micro-ops one per scheduler acknowledge, in order. A single-group station stalls decode until its group drains; this queue decouples decode from execute. It adds a flush input, an explicit last-uop flag and occupancy reporting.

## Interface
- UOP_W, 20, micro-op width
- K_W, 16, operand/temp word width
- SLOTS, 3, max micro-ops per group (≥1)
- DEPTH, 4, groups buffered (power of two, ≥2)
- NOP, 20'b0000_0000_1111_00_000_000, micro-op driven when empty (UOP_W bits)
- clk  in  1  clock, all state on rising edge
- a_rst  in  1  asynchronous active-low reset
- id_feed_req  out  1  queue can accept a group this cycle
- id_feed_ack  in  1  decode pushes a group; honoured only when id_feed_req=1
- id_uops  in  SLOTS*UOP_W  group micro-ops, slot 0 in bits [UOP_W-1:0]
- id_uop_count  in  CW=$clog2(SLOTS+1)  valid slots in group, 0..SLOTS
- id_k16  in  K_W  initial temp word of group
- ex_uop_next  out  UOP_W  current micro-op of head group, NOP when empty
- ex_is_last  out  1  ex_uop_next is final slot of head group
- ex_is_valid  out  1  queue non-empty
- ex_sched_ack  in  1  scheduler consumes ex_uop_next; ignored when ex_is_valid=0
- mem_data_in  in  K_W  memory result for head group temp
- mem_data_wr  in  1  write mem_data_in to head group temp
- ex_data_out  out  K_W  head group temp, 0 when empty
- flush  in  1  synchronous discard of all groups
- occupancy  out  $clog2(DEPTH+1)  groups held

## Operation
- Storage: circular buffer of DEPTH entries {uops, count, temp}. Pointers are wr_ptr and rd_ptr, each log2(DEPTH) bits, and wrap modulo DEPTH. Occupancy counter runs 0..DEPTH. Slot pointer `idx` runs 0..SLOTS-1 within the head group.
- Push: id_feed_ack & id_feed_req & id_uop_count≠0 writes the entry at wr_ptr. A count of 0 is accepted and dropped, with no entry written.
- Issue: ex_uop_next = head.uops[idx]. ex_is_last = (idx == head.count-1).
- Acknowledge: ex_sched_ack & ex_is_valid & ~ex_is_last increments idx. ex_sched_ack & ex_is_last pops the head and clears idx to 0.
- id_feed_req = (occupancy<DEPTH) | (ex_sched_ack & ex_is_last). It is combinational from ex_sched_ack, so a push is allowed on the cycle a full queue pops.
- Push and pop in the same cycle leave occupancy unchanged.
- mem_data_wr updates head.temp when the queue is non-empty. It is ignored when empty. If it coincides with a pop, the write is discarded.
- Flush has priority over push, pop and mem write. Next cycle: occupancy=0, pointers=0, idx=0. id_feed_req is still driven normally during the flush cycle, but a push in that cycle is dropped.
- Reset state: all pointers, idx and occupancy are 0, entries are cleared, and the queue is empty.

## Timing
- Outputs after reset: ex_is_valid=0, ex_is_last=0, ex_uop_next=NOP, ex_data_out=0, occupancy=0, id_feed_req=1.
- Push-to-issue latency is 1 cycle: a group pushed at edge N is visible on ex_uop_next after edge N. There is no same-cycle bypass.
- One micro-op per cycle maximum. Back-to-back groups issue with no bubble.
- The mem write is visible on ex_data_out the cycle after the write edge.
- a_rst asserted mid-operation clears state immediately, without waiting for clk. In-flight groups are lost.
- ex_uop_next, ex_is_last and ex_data_out are combinational from the registered head entry and idx only, with no input-to-output path. id_feed_req is the only output with a combinational input path (ex_sched_ack).

## Structure
- Shared package uop_pkg holds UOP_W, K_W, the NOP constant and the group entry struct/typedef {uops, count, temp}.
- One sub-module, uop_group_mem: a DEPTH×entry register file with one write port and one read port, plus a per-entry temp write port.
- Control (pointers, idx, occupancy, flush) lives in the top module.

## Test plan
- Reset then idle -> ex_uop_next=NOP, ex_is_valid=0, id_feed_req=1, occupancy=0. Assert a_rst mid-group -> all outputs return to these values without a clock edge.
- Push group {A,B,C}, count=3, k16=16'h1234, then ack every cycle -> issues A, B, C on consecutive cycles. ex_is_last=1 only with C. ex_data_out=16'h1234. Queue is empty after C.
- Push 4 groups of count 1 with no ack -> occupancy=4, id_feed_req=0. Ack with a simultaneous push -> push accepted, occupancy stays 4, FIFO order preserved.
- Push count=0 -> occupancy stays 0. Push count=2 with k16=0 and mem_data_wr=1 with mem_data_in=16'hBEEF -> ex_data_out=16'hBEEF next cycle. A write coinciding with the pop of that group does not reach the next group.
- Fill 3 groups, then flush with a simultaneous push and ack -> occupancy=0 and ex_uop_next=NOP next cycle. The pushed group is dropped.
- Randomised push/ack/mem_wr for 10k cycles against a scoreboard model, wrapping the pointers at least 100 times -> no order, count or temp mismatch.

Source files
------------

// File: rtl/uop_pkg.sv
// Shared configuration and the group entry layout for the uop group queue.
// Holds widths, queue geometry, the NOP micro-op and the grp_t record.
package uop_pkg;

    localparam int UOP_W = 20;
    localparam int K_W   = 16;
    localparam int SLOTS = 3;
    localparam int DEPTH = 4;

    localparam int CW = $clog2(SLOTS + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);
    localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    localparam logic [UOP_W-1:0] NOP = 20'b0000_0000_1111_00_000_000;

    typedef struct packed {
        logic [SLOTS-1:0][UOP_W-1:0] uops;
        logic [CW-1:0]               count;
        logic [K_W-1:0]              temp;
    } grp_t;

endpackage

// File: rtl/uop_group_mem.sv
// DEPTH x grp_t register file: one full-entry write port, one temp-only
// write port and one asynchronous read port.
// Ports: clk, a_rst (async active-low), i_we/i_waddr/i_wdata (entry write),
//        i_twe/i_taddr/i_tdata (temp write), i_raddr/o_rdata (read).
module uop_group_mem
    import uop_pkg::*;
(
    input  logic          clk,
    input  logic          a_rst,
    input  logic          i_we,
    input  logic [PW-1:0] i_waddr,
    input  grp_t          i_wdata,
    input  logic          i_twe,
    input  logic [PW-1:0] i_taddr,
    input  logic [K_W-1:0] i_tdata,
    input  logic [PW-1:0] i_raddr,
    output grp_t          o_rdata
);

    grp_t r_mem [DEPTH];

    // A full-entry write wins if both ports ever target the same entry.
    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_we && (i_waddr == PW'(i))) begin
                    r_mem[i] <= i_wdata;
                end else if (i_twe && (i_taddr == PW'(i))) begin
                    r_mem[i].temp <= i_tdata;
                end
            end
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uop_group_queue.sv
// Reservation queue of decoded micro-op groups between decode and the
// execute scheduler; issues one micro-op per scheduler acknowledge.
// Ports: clk, a_rst; decode side id_feed_req/ack, id_uops, id_uop_count,
//        id_k16; execute side ex_uop_next, ex_is_last, ex_is_valid,
//        ex_sched_ack, ex_data_out; mem_data_in/wr; flush; occupancy.
module uop_group_queue
    import uop_pkg::*;
(
    input  logic                   clk,
    input  logic                   a_rst,
    output logic                   id_feed_req,
    input  logic                   id_feed_ack,
    input  logic [SLOTS*UOP_W-1:0] id_uops,
    input  logic [CW-1:0]          id_uop_count,
    input  logic [K_W-1:0]         id_k16,
    output logic [UOP_W-1:0]       ex_uop_next,
    output logic                   ex_is_last,
    output logic                   ex_is_valid,
    input  logic                   ex_sched_ack,
    input  logic [K_W-1:0]         mem_data_in,
    input  logic                   mem_data_wr,
    output logic [K_W-1:0]         ex_data_out,
    input  logic                   flush,
    output logic [OW-1:0]          occupancy
);

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [OW-1:0] r_occ;
    logic [SW-1:0] r_idx;

    grp_t w_head;
    grp_t w_wdata;
    logic w_valid;
    logic w_last;
    logic w_pop;
    logic w_adv;
    logic w_push;
    logic w_twe;

    assign w_valid = (r_occ != '0);
    assign w_last  = w_valid
                   && ((32'(r_idx) + 32'd1) == 32'(w_head.count));
    assign w_pop   = ex_sched_ack & w_last;
    assign w_adv   = ex_sched_ack & w_valid & ~w_last;

    // A popping full queue frees its slot in the same cycle.
    assign id_feed_req = (r_occ < OW'(DEPTH)) | w_pop;

    // Empty groups are acknowledged but never stored.
    assign w_push = id_feed_ack & id_feed_req
                  & (id_uop_count != '0) & ~flush;

    // A temp write racing the pop of its group is dropped.
    assign w_twe = mem_data_wr & w_valid & ~w_pop & ~flush;

    assign w_wdata.uops  = id_uops;
    assign w_wdata.count = id_uop_count;
    assign w_wdata.temp  = id_k16;

    uop_group_mem u_mem (
        .clk     (clk),
        .a_rst   (a_rst),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wdata),
        .i_twe   (w_twe),
        .i_taddr (r_rd_ptr),
        .i_tdata (mem_data_in),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_head)
    );

    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            r_idx    <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            r_idx    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_idx    <= '0;
            end else if (w_adv) begin
                r_idx    <= r_idx + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign ex_is_valid = w_valid;
    assign ex_is_last  = w_last;
    assign ex_uop_next = w_valid ? w_head.uops[r_idx] : NOP;
    assign ex_data_out = w_valid ? w_head.temp : '0;
    assign occupancy   = r_occ;

endmodule

// File: tb/tb_uop_group_queue.sv
// Self-checking bench for uop_group_queue: directed vector table,
// async reset sequence and a randomised scoreboard run.
module tb_uop_group_queue;
    import uop_pkg::*;

    logic                   clk;
    logic                   a_rst;
    logic                   id_feed_req;
    logic                   id_feed_ack;
    logic [SLOTS*UOP_W-1:0] id_uops;
    logic [CW-1:0]          id_uop_count;
    logic [K_W-1:0]         id_k16;
    logic [UOP_W-1:0]       ex_uop_next;
    logic                   ex_is_last;
    logic                   ex_is_valid;
    logic                   ex_sched_ack;
    logic [K_W-1:0]         mem_data_in;
    logic                   mem_data_wr;
    logic [K_W-1:0]         ex_data_out;
    logic                   flush;
    logic [OW-1:0]          occupancy;

    int checks;
    int failures;

    uop_group_queue dut (
        .clk          (clk),
        .a_rst        (a_rst),
        .id_feed_req  (id_feed_req),
        .id_feed_ack  (id_feed_ack),
        .id_uops      (id_uops),
        .id_uop_count (id_uop_count),
        .id_k16       (id_k16),
        .ex_uop_next  (ex_uop_next),
        .ex_is_last   (ex_is_last),
        .ex_is_valid  (ex_is_valid),
        .ex_sched_ack (ex_sched_ack),
        .mem_data_in  (mem_data_in),
        .mem_data_wr  (mem_data_wr),
        .ex_data_out  (ex_data_out),
        .flush        (flush),
        .occupancy    (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             push;
        logic [CW-1:0]    cnt;
        logic [UOP_W-1:0] u0, u1, u2;
        logic [K_W-1:0]   k;
        logic             ack;
        logic             mw;
        logic [K_W-1:0]   md;
        logic             fl;
        logic             ev;
        logic [UOP_W-1:0] eu;
        logic             el;
        logic [K_W-1:0]   ed;
        logic [OW-1:0]    eo;
        logic             er;
    } vec_t;

    vec_t tv[$];

    localparam logic [UOP_W-1:0] A = 20'hAAAA1, B = 20'hBBBB2;
    localparam logic [UOP_W-1:0] C = 20'hCCCC3, D = 20'hDDDD4;
    localparam logic [UOP_W-1:0] E = 20'hEEEE5, F = 20'hFFFF6;
    localparam logic [UOP_W-1:0] G = 20'h12347, H = 20'h23458;
    localparam logic [UOP_W-1:0] X = 20'h34569, P = 20'h4567A;
    localparam logic [UOP_W-1:0] Q = 20'h5678B, R = 20'h6789C;
    localparam logic [UOP_W-1:0] S = 20'h789AD, T = 20'h89ABE;
    localparam logic [UOP_W-1:0] U = 20'h9ABCF, Z = 20'h00000;

    task automatic add(input logic push, input int cnt,
                       input logic [UOP_W-1:0] u0, u1, u2,
                       input logic [K_W-1:0] k, input logic ack,
                       input logic mw, input logic [K_W-1:0] md,
                       input logic fl, input logic ev,
                       input logic [UOP_W-1:0] eu, input logic el,
                       input logic [K_W-1:0] ed, input int eo,
                       input logic er);
        vec_t v;
        v.push = push; v.cnt = CW'(cnt);
        v.u0 = u0; v.u1 = u1; v.u2 = u2; v.k = k;
        v.ack = ack; v.mw = mw; v.md = md; v.fl = fl;
        v.ev = ev; v.eu = eu; v.el = el; v.ed = ed;
        v.eo = OW'(eo); v.er = er;
        tv.push_back(v);
    endtask

    task automatic drive(input logic push, input logic [CW-1:0] cnt,
                         input logic [UOP_W-1:0] u0, u1, u2,
                         input logic [K_W-1:0] k, input logic ack,
                         input logic mw, input logic [K_W-1:0] md,
                         input logic fl);
        id_feed_ack  = push;
        id_uop_count = cnt;
        id_uops      = {u2, u1, u0};
        id_k16       = k;
        ex_sched_ack = ack;
        mem_data_wr  = mw;
        mem_data_in  = md;
        flush        = fl;
    endtask

    task automatic check(input string name, input logic ev,
                         input logic [UOP_W-1:0] eu, input logic el,
                         input logic [K_W-1:0] ed, input logic [OW-1:0] eo,
                         input logic er);
        checks++;
        if ({ex_is_valid, ex_uop_next, ex_is_last, ex_data_out,
             occupancy, id_feed_req} !== {ev, eu, el, ed, eo, er}) begin
            failures++;
            $display("FAIL %s: got v=%0b u=%h l=%0b d=%h o=%0d r=%0b exp v=%0b u=%h l=%0b d=%h o=%0d r=%0b",
                     name, ex_is_valid, ex_uop_next, ex_is_last,
                     ex_data_out, occupancy, id_feed_req,
                     ev, eu, el, ed, eo, er);
        end
    endtask

    // Scoreboard model
    typedef struct {
        logic [UOP_W-1:0] u [3];
        int               cnt;
        logic [K_W-1:0]   temp;
    } mgrp_t;

    mgrp_t mq[$];
    int    midx;

    initial begin
        string nm;
        checks = 0;
        failures = 0;
        a_rst = 1'b0;
        drive(0, 0, Z, Z, Z, 0, 0, 0, 0, 0);
        #12 a_rst = 1'b1;

        // push, ack, ..., expected state seen this cycle before the edge
        add(0,0,Z,Z,Z,16'h0,0,0,0,0, 0,NOP,0,16'h0,0,1);
        add(1,3,A,B,C,16'h1234,0,0,0,0, 0,NOP,0,16'h0,0,1);
        add(0,0,Z,Z,Z,16'h0,1,0,0,0, 1,A,0,16'h1234,1,1);
        add(0,0,Z,Z,Z,16'h0,1,0,0,0, 1,B,0,16'h1234,1,1);
        add(0,0,Z,Z,Z,16'h0,1,0,0,0, 1,C,1,16'h1234,1,1);
        add(0,0,Z,Z,Z,16'h0,0,0,0,0, 0,NOP,0,16'h0,0,1);
        add(1,1,D,Z,Z,16'h0001,0,0,0,0, 0,NOP,0,16'h0,0,1);
        add(1,1,E,Z,Z,16'h0002,0,0,0,0, 1,D,1,16'h0001,1,1);
        add(1,1,F,Z,Z,16'h0003,0,0,0,0, 1,D,1,16'h0001,2,1);
        add(1,1,G,Z,Z,16'h0004,0,0,0,0, 1,D,1,16'h0001,3,1);
        add(1,1,X,Z,Z,16'h0009,0,0,0,0, 1,D,1,16'h0001,4,0);
        add(1,1,H,Z,Z,16'h0005,1,0,0,0, 1,D,1,16'h0001,4,1);
        add(0,0,Z,Z,Z,16'h0,1,0,0,0, 1,E,1,16'h0002,4,1);
        add(0,0,Z,Z,Z,16'h0,1,0,0,0, 1,F,1,16'h0003,3,1);
        add(0,0,Z,Z,Z,16'h0,1,0,0,0, 1,G,1,16'h0004,2,1);
        add(0,0,Z,Z,Z,16'h0,1,0,0,0, 1,H,1,16'h0005,1,1);
        add(0,0,Z,Z,Z,16'h0,0,0,0,0, 0,NOP,0,16'h0,0,1);
        add(1,0,X,X,X,16'h5A5A,0,0,0,0, 0,NOP,0,16'h0,0,1);
        add(0,0,Z,Z,Z,16'h0,0,0,0,0, 0,NOP,0,16'h0,0,1);
        add(1,2,P,Q,Z,16'h0000,0,0,0,0, 0,NOP,0,16'h0,0,1);
        add(1,1,R,Z,Z,16'h7777,0,1,16'hBEEF,0, 1,P,0,16'h0000,1,1);
        add(0,0,Z,Z,Z,16'h0,0,0,0,0, 1,P,0,16'hBEEF,2,1);
        add(0,0,Z,Z,Z,16'h0,1,0,0,0, 1,P,0,16'hBEEF,2,1);
        add(0,0,Z,Z,Z,16'h0,1,1,16'h1111,0, 1,Q,1,16'hBEEF,2,1);
        add(0,0,Z,Z,Z,16'h0,0,0,0,0, 1,R,1,16'h7777,1,1);
        add(0,0,Z,Z,Z,16'h0,1,0,0,0, 1,R,1,16'h7777,1,1);
        add(0,0,Z,Z,Z,16'h0,0,0,0,0, 0,NOP,0,16'h0,0,1);
        add(1,1,S,Z,Z,16'h0001,0,0,0,0, 0,NOP,0,16'h0,0,1);
        add(1,1,T,Z,Z,16'h0002,0,0,0,0, 1,S,1,16'h0001,1,1);
        add(1,1,U,Z,Z,16'h0003,0,0,0,0, 1,S,1,16'h0001,2,1);
        add(1,1,X,Z,Z,16'h0004,1,1,16'h4444,1, 1,S,1,16'h0001,3,1);
        add(0,0,Z,Z,Z,16'h0,0,0,0,0, 0,NOP,0,16'h0,0,1);
        add(0,0,Z,Z,Z,16'h0,0,1,16'h5555,0, 0,NOP,0,16'h0,0,1);
        add(1,1,U,Z,Z,16'h0006,0,0,0,0, 0,NOP,0,16'h0,0,1);
        add(0,0,Z,Z,Z,16'h0,0,0,0,0, 1,U,1,16'h0006,1,1);
        add(0,0,Z,Z,Z,16'h0,1,0,0,0, 1,U,1,16'h0006,1,1);
        add(0,0,Z,Z,Z,16'h0,0,0,0,0, 0,NOP,0,16'h0,0,1);

        @(posedge clk);
        for (int i = 0; i < tv.size(); i++) begin
            #1;
            drive(tv[i].push, tv[i].cnt, tv[i].u0, tv[i].u1, tv[i].u2,
                  tv[i].k, tv[i].ack, tv[i].mw, tv[i].md, tv[i].fl);
            @(negedge clk);
            nm = $sformatf("vec%0d", i);
            check(nm, tv[i].ev, tv[i].eu, tv[i].el, tv[i].ed,
                  tv[i].eo, tv[i].er);
            @(posedge clk);
        end

        // Async reset mid-group
        #1 drive(1, 3, A, B, C, 16'h4321, 0, 0, 0, 0);
        @(posedge clk);
        #1 drive(1, 2, D, E, Z, 16'h9999, 1, 0, 0, 0);
        @(posedge clk);
        #1 drive(0, 0, Z, Z, Z, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("pre_reset", 1, B, 0, 16'h4321, 2, 1);
        #2 a_rst = 1'b0;
        #1 check("async_reset", 0, NOP, 0, 16'h0, 0, 1);
        @(posedge clk);
        #1 check("reset_held", 0, NOP, 0, 16'h0, 0, 1);
        @(negedge clk);
        a_rst = 1'b1;
        @(posedge clk);

        // Randomised run against the scoreboard
        mq.delete();
        midx = 0;
        for (int c = 0; c < 10000; c++) begin
            logic             p, a, mw, fl;
            logic [CW-1:0]    cn;
            logic [UOP_W-1:0] r0, r1, r2;
            logic [K_W-1:0]   k, md;
            logic             ev, el, er, pop;
            logic [UOP_W-1:0] eu;
            logic [K_W-1:0]   ed;
            p  = ($urandom_range(0, 9) < 6);
            cn = CW'($urandom_range(0, 3));
            r0 = UOP_W'($urandom);
            r1 = UOP_W'($urandom);
            r2 = UOP_W'($urandom);
            k  = K_W'($urandom);
            a  = ($urandom_range(0, 9) < 7);
            mw = ($urandom_range(0, 9) < 2);
            md = K_W'($urandom);
            fl = ($urandom_range(0, 299) == 0);
            #1 drive(p, cn, r0, r1, r2, k, a, mw, md, fl);
            ev  = (mq.size() > 0);
            el  = ev && (midx == mq[0].cnt - 1);
            eu  = ev ? mq[0].u[midx] : NOP;
            ed  = ev ? mq[0].temp : '0;
            pop = a && el;
            er  = (mq.size() < DEPTH) || pop;
            @(negedge clk);
            check($sformatf("rand%0d", c), ev, eu, el, ed,
                  OW'(mq.size()), er);
            if (fl) begin
                mq.delete();
                midx = 0;
            end else begin
                if (mw && ev && !pop) mq[0].temp = md;
                if (a && ev) begin
                    if (el) begin
                        void'(mq.pop_front());
                        midx = 0;
                    end else begin
                        midx++;
                    end
                end
                if (p && er && cn != 0) begin
                    mgrp_t g;
                    g.u[0] = r0; g.u[1] = r1; g.u[2] = r2;
                    g.cnt = int'(cn);
                    g.temp = k;
                    mq.push_back(g);
                end
            end
            @(posedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
